rf_wb_sched: RTL and testbench

- Register-file writeback scheduler and scoreboard for the RV32I core.
- Sits between the issue stage, the two result producers (ALU and LSU), and reg_file's single write port.
- Tracks pending destination registers and stalls issue on RAW/WAW hazards.
- Arbitrates the one write port between ALU and LSU and drives the registered write-port signals.

---
 rtl/rf_wb_sched.sv | 125 ++++++++++++
 tb/tb_rf_wb_sched.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_sched.sv
// rf_wb_sched: register-file writeback scheduler and scoreboard for the RV32I core.
//   Tracks pending destination registers, stalls issue on RAW/WAW hazards, round-robin
//   arbitrates ALU/LSU results onto the single reg_file write port (registered outputs).
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   issue_valid/ready/rs1/rs2/wr/rd  issue stage handshake and operands (ready is combinational)
//   alu_wb_valid/ready/rd/data       ALU result handshake
//   lsu_wb_valid/ready/rd/data       LSU result handshake
//   rf_wr_en/addr/data               registered reg_file write port
//   busy_vec, busy_cnt               pending-write bitmap and its population count
//   sb_err                           sticky scoreboard error
// Optional: define RF_SB_CHECK_EN to build the sb_err checker; otherwise sb_err is tied 0.
module rf_wb_sched #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [AW-1:0]   issue_rs1,
    input  logic [AW-1:0]   issue_rs2,
    input  logic            issue_wr,
    input  logic [AW-1:0]   issue_rd,
    input  logic            alu_wb_valid,
    output logic            alu_wb_ready,
    input  logic [AW-1:0]   alu_wb_rd,
    input  logic [XLEN-1:0] alu_wb_data,
    input  logic            lsu_wb_valid,
    output logic            lsu_wb_ready,
    input  logic [AW-1:0]   lsu_wb_rd,
    input  logic [XLEN-1:0] lsu_wb_data,
    output logic            rf_wr_en,
    output logic [AW-1:0]   rf_wr_addr,
    output logic [XLEN-1:0] rf_wr_data,
    output logic [NREG-1:0] busy_vec,
    output logic [AW:0]     busy_cnt,
    output logic            sb_err
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;
    logic            rr_q, rr_d;
    logic            grant, set, clr;
    logic [AW-1:0]   g_rd;
    logic [XLEN-1:0] g_data;

    // rr_q = 0 favours ALU on contention, 1 favours LSU
    always_comb begin
        issue_ready  = !(issue_rs1 != '0 && busy_q[issue_rs1]) &&
                       !(issue_rs2 != '0 && busy_q[issue_rs2]) &&
                       !(issue_wr && issue_rd != '0 && busy_q[issue_rd]);
        alu_wb_ready = alu_wb_valid && (!lsu_wb_valid || !rr_q);
        lsu_wb_ready = lsu_wb_valid && (!alu_wb_valid || rr_q);
        rr_d         = (alu_wb_valid && lsu_wb_valid) ? !rr_q : rr_q;
        grant        = alu_wb_ready || lsu_wb_ready;
        g_rd         = lsu_wb_ready ? lsu_wb_rd : alu_wb_rd;
        g_data       = lsu_wb_ready ? lsu_wb_data : alu_wb_data;
        wr_en_d      = grant && g_rd != '0;
        wr_addr_d    = wr_en_d ? g_rd : wr_addr_q;
        wr_data_d    = wr_en_d ? g_data : wr_data_q;
        set          = issue_valid && issue_ready && issue_wr && issue_rd != '0;
        // Only count a clear when the bit is really set so the count tracks popcount
        // even for a spurious writeback.
        clr          = wr_en_q && busy_q[wr_addr_q];
        busy_d       = busy_q;
        if (clr)
            busy_d[wr_addr_q] = 1'b0;
        if (set)
            busy_d[issue_rd] = 1'b1;
        busy_d[0]    = 1'b0;
        cnt_d        = cnt_q + (AW+1)'(set) - (AW+1)'(clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rr_q      <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rr_q      <= rr_d;
        end
    end

    assign rf_wr_en   = wr_en_q;
    assign rf_wr_addr = wr_addr_q;
    assign rf_wr_data = wr_data_q;
    assign busy_vec   = busy_q;
    assign busy_cnt   = cnt_q;

`ifdef RF_SB_CHECK_EN
    logic err_q, err_d;

    // Spurious writeback (granted rd not pending) or both producers targeting the same rd.
    always_comb begin
        err_d = err_q ||
                (grant && g_rd != '0 && !busy_q[g_rd]) ||
                (alu_wb_valid && lsu_wb_valid && alu_wb_rd == lsu_wb_rd && alu_wb_rd != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign sb_err = err_q;
`else
    assign sb_err = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_sched.sv
// tb_rf_wb_sched: directed table-driven bench for rf_wb_sched plus reset and scoreboard-error sequences.
module tb_rf_wb_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0, issue_ready, issue_wr = 1'b0;
    logic [4:0]  issue_rs1 = '0, issue_rs2 = '0, issue_rd = '0;
    logic        alu_wb_valid = 1'b0, alu_wb_ready, lsu_wb_valid = 1'b0, lsu_wb_ready;
    logic [4:0]  alu_wb_rd = '0, lsu_wb_rd = '0;
    logic [31:0] alu_wb_data = '0, lsu_wb_data = '0;
    logic        rf_wr_en, sb_err;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data, busy_vec;
    logic [5:0]  busy_cnt;

    int n_tests = 0;
    int n_fail = 0;

`ifdef RF_SB_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    rf_wb_sched dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_wr(issue_wr), .issue_rd(issue_rd),
        .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
        .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
        .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .busy_vec(busy_vec), .busy_cnt(busy_cnt), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [4:0]  rs1, rs2;
        logic        wr;
        logic [4:0]  rd;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        ir, ar, lr, we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] bv;
        logic [5:0]  bc;
    } vec_t;

    vec_t tbl[29];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic wr, input logic [4:0] rd,
                         input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        issue_valid = iv; issue_rs1 = rs1; issue_rs2 = rs2; issue_wr = wr; issue_rd = rd;
        alu_wb_valid = av; alu_wb_rd = ard; alu_wb_data = ad;
        lsu_wb_valid = lv; lsu_wb_rd = lrd; lsu_wb_data = ld;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " rf_wr_en"}, 32'(rf_wr_en), 0);
        chk({tag, " rf_wr_addr"}, 32'(rf_wr_addr), 0);
        chk({tag, " rf_wr_data"}, rf_wr_data, 0);
        chk({tag, " busy_vec"}, busy_vec, 0);
        chk({tag, " busy_cnt"}, 32'(busy_cnt), 0);
        chk({tag, " sb_err"}, 32'(sb_err), 0);
    endtask

    initial begin
        // iv rs1 rs2 wr rd | av ard ad | lv lrd ld | ir ar lr we wa wd bv bc
        tbl[0]  = '{1,0,0,1,5, 0,0,0, 0,0,0, 1,0,0,0,0,0,'h0,0};
        tbl[1]  = '{1,5,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0,'h20,1};
        tbl[2]  = '{1,5,0,0,0, 1,5,'hDEADBEEF, 0,0,0, 0,1,0,0,0,0,'h20,1};
        tbl[3]  = '{1,5,0,0,0, 0,0,0, 0,0,0, 0,0,0,1,5,'hDEADBEEF,'h20,1};
        tbl[4]  = '{1,5,0,0,0, 0,0,0, 0,0,0, 1,0,0,0,0,0,'h0,0};
        tbl[5]  = '{1,0,0,1,1, 0,0,0, 0,0,0, 1,0,0,0,0,0,'h0,0};
        tbl[6]  = '{1,0,0,1,2, 0,0,0, 0,0,0, 1,0,0,0,0,0,'h2,1};
        tbl[7]  = '{1,0,0,1,3, 0,0,0, 0,0,0, 1,0,0,0,0,0,'h6,2};
        tbl[8]  = '{1,0,0,1,4, 0,0,0, 0,0,0, 1,0,0,0,0,0,'hE,3};
        tbl[9]  = '{0,0,0,0,0, 1,1,'h11, 1,2,'h22, 1,1,0,0,0,0,'h1E,4};
        tbl[10] = '{0,0,0,0,0, 1,3,'h33, 1,2,'h22, 1,0,1,1,1,'h11,'h1E,4};
        tbl[11] = '{0,0,0,0,0, 1,3,'h33, 1,4,'h44, 1,1,0,1,2,'h22,'h1C,3};
        tbl[12] = '{0,0,0,0,0, 1,0,'h55, 1,4,'h44, 1,0,1,1,3,'h33,'h18,2};
        tbl[13] = '{0,0,0,0,0, 1,0,'h55, 0,0,0, 1,1,0,1,4,'h44,'h10,1};
        tbl[14] = '{0,0,0,0,0, 0,0,0, 0,0,0, 1,0,0,0,0,0,'h0,0};
        tbl[15] = '{1,0,0,1,0, 0,0,0, 0,0,0, 1,0,0,0,0,0,'h0,0};
        tbl[16] = '{0,0,0,0,0, 1,0,'h99, 0,0,0, 1,1,0,0,0,0,'h0,0};
        tbl[17] = '{0,0,0,0,0, 0,0,0, 0,0,0, 1,0,0,0,0,0,'h0,0};
        tbl[18] = '{1,0,0,1,7, 0,0,0, 0,0,0, 1,0,0,0,0,0,'h0,0};
        tbl[19] = '{1,0,0,1,7, 0,0,0, 0,0,0, 0,0,0,0,0,0,'h80,1};
        tbl[20] = '{1,0,0,1,7, 0,0,0, 1,7,'h77, 0,0,1,0,0,0,'h80,1};
        tbl[21] = '{1,0,0,1,7, 0,0,0, 0,0,0, 0,0,0,1,7,'h77,'h80,1};
        tbl[22] = '{1,0,0,1,7, 0,0,0, 0,0,0, 1,0,0,0,0,0,'h0,0};
        tbl[23] = '{0,0,7,0,0, 1,7,'h70, 0,0,0, 0,1,0,0,0,0,'h80,1};
        tbl[24] = '{1,0,0,1,6, 0,0,0, 0,0,0, 1,0,0,1,7,'h70,'h80,1};
        tbl[25] = '{0,6,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0,'h40,1};
        tbl[26] = '{0,6,0,0,0, 1,6,'h66, 0,0,0, 0,1,0,0,0,0,'h40,1};
        tbl[27] = '{0,6,0,0,0, 0,0,0, 0,0,0, 0,0,0,1,6,'h66,'h40,1};
        tbl[28] = '{0,6,0,0,0, 0,0,0, 0,0,0, 1,0,0,0,0,0,'h0,0};

        // Reset state
        @(negedge clk);
        #1 chk_zero("reset");
        chk("reset issue_ready", 32'(issue_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].iv, tbl[i].rs1, tbl[i].rs2, tbl[i].wr, tbl[i].rd,
                  tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].lv, tbl[i].lrd, tbl[i].ld);
            #1;
            chk($sformatf("row%0d issue_ready", i), 32'(issue_ready), 32'(tbl[i].ir));
            chk($sformatf("row%0d alu_wb_ready", i), 32'(alu_wb_ready), 32'(tbl[i].ar));
            chk($sformatf("row%0d lsu_wb_ready", i), 32'(lsu_wb_ready), 32'(tbl[i].lr));
            chk($sformatf("row%0d rf_wr_en", i), 32'(rf_wr_en), 32'(tbl[i].we));
            if (tbl[i].we) begin
                chk($sformatf("row%0d rf_wr_addr", i), 32'(rf_wr_addr), 32'(tbl[i].wa));
                chk($sformatf("row%0d rf_wr_data", i), rf_wr_data, tbl[i].wd);
            end
            chk($sformatf("row%0d busy_vec", i), busy_vec, tbl[i].bv);
            chk($sformatf("row%0d busy_cnt", i), 32'(busy_cnt), 32'(tbl[i].bc));
            chk($sformatf("row%0d sb_err", i), 32'(sb_err), 0);
        end

        // Mid-cycle reset with x4..x7 pending, a write in flight and the pointer at LSU
        for (int r = 4; r < 8; r++) begin
            @(negedge clk);
            drive(1, 0, 0, 1, 5'(r), 0, 0, 0, 0, 0, 0);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1, 4, 'hCAFE, 1, 0, 'h1);
        #1 chk("pre-reset alu_wb_ready", 32'(alu_wb_ready), 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h1);
        #1;
        chk("pre-reset busy_vec", busy_vec, 'hF0);
        chk("pre-reset rf_wr_en", 32'(rf_wr_en), 1);
        chk("pre-reset rf_wr_data", rf_wr_data, 'hCAFE);
        #1 rst_n = 1'b0;
        #1 chk_zero("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 4, 5, 1, 6, 1, 0, 0, 1, 0, 0);
        #1;
        chk("post-reset issue_ready", 32'(issue_ready), 1);
        chk("post-reset rr alu_wb_ready", 32'(alu_wb_ready), 1);
        chk("post-reset rr lsu_wb_ready", 32'(lsu_wb_ready), 0);

        // Spurious LSU writeback to x9
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 'h9);
        #1 chk("spur lsu_wb_ready", 32'(lsu_wb_ready), 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("spur rf_wr_en", 32'(rf_wr_en), 1);
        chk("spur rf_wr_addr", 32'(rf_wr_addr), 9);
        chk("spur sb_err", 32'(sb_err), 32'(ERR_EXP));
        repeat (3) @(negedge clk);
        #1;
        chk("spur sb_err sticky", 32'(sb_err), 32'(ERR_EXP));
        chk("spur busy_cnt", 32'(busy_cnt), 0);
        chk("spur busy_vec", busy_vec, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
